// File: rtl/biriscv_mulf.sv
// biriscv_mulf: multi-cycle binary32 multiplier. Radix-2 shift-add of
// the 24-bit significands (one multiplier bit per cycle), followed by a
// single normalise/round-to-nearest-even cycle. NaN, infinity and zero
// operands bypass the datapath and complete one cycle after issue.
module biriscv_mulf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic        inst_mulf_i,
  input  logic [31:0] operand_ra_i,
  input  logic [31:0] operand_rb_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        mulf_complete_o,
  output logic [31:0] mulf_result_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [4:0]         cnt_q;

  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [23:0]        mcand_q;
  logic [47:0]        prod_q;
  logic [24:0]        mul_sum;

  // Operand classification
  logic [7:0]         a_exp;
  logic [7:0]         b_exp;
  logic [22:0]        a_man;
  logic [22:0]        b_man;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               special;
  logic [31:0]        special_res;
  logic               res_sign;
  logic signed [9:0]  exp_sum;
  logic               accept;

  assign a_exp  = operand_ra_i[30:23];
  assign b_exp  = operand_rb_i[30:23];
  assign a_man  = operand_ra_i[22:0];
  assign b_man  = operand_rb_i[22:0];

  // Subnormal inputs are folded into zero.
  assign a_zero = (a_exp == 8'h00);
  assign b_zero = (b_exp == 8'h00);
  assign a_inf  = (a_exp == 8'hFF) && (a_man == 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_man == 23'd0);
  assign a_nan  = (a_exp == 8'hFF) && (a_man != 23'd0);
  assign b_nan  = (b_exp == 8'hFF) && (b_man != 23'd0);

  assign res_sign = operand_ra_i[31] ^ operand_rb_i[31];
  assign special  = a_zero | b_zero | a_exp == 8'hFF | b_exp == 8'hFF;
  assign exp_sum  = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 10'sd127;

  assign accept = (state_q == ST_IDLE) & opcode_valid_i & inst_mulf_i & ~flush_i;

  // Fast-path result for non-finite or zero operands
  always_comb begin
    special_res = {res_sign, 31'd0};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      special_res = 32'h7FC00000;
    else if (a_inf || b_inf)
      special_res = {res_sign, 8'hFF, 23'd0};
  end

  // One shift-add step: add multiplicand to the upper half when the
  // current multiplier bit (LSB) is set, then shift the whole product right.
  assign mul_sum = {1'b0, prod_q[47:24]} + (prod_q[0] ? {1'b0, mcand_q} : 25'd0);

  // Normalise the 48-bit product, round to nearest even, and clamp the
  // exponent to infinity or zero.
  function automatic logic [31:0] norm_round(input logic sign,
                                             input logic signed [9:0] exp_in,
                                             input logic [47:0] p);
    logic signed [9:0] e;
    logic [22:0]       m;
    logic              g;
    logic              s;
    logic              rnd;
    logic [24:0]       r;
    if (p[47]) begin
      m = p[46:24];
      g = p[23];
      s = |p[22:0];
      e = exp_in + 10'sd1;
    end else begin
      m = p[45:23];
      g = p[22];
      s = |p[21:0];
      e = exp_in;
    end
    rnd = g & (s | m[0]);
    r   = {2'b01, m} + {24'd0, rnd};
    if (r[24]) begin
      e = e + 10'sd1;
      m = r[23:1];
    end else begin
      m = r[22:0];
    end
    if (e >= 10'sd255)
      norm_round = {sign, 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      norm_round = {sign, 31'd0};
    else
      norm_round = {sign, e[7:0], m};
  endfunction

  // Control: state machine, counter, completion pulse and result register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 5'd0;
      mulf_complete_o <= 1'b0;
      mulf_result_o   <= 32'd0;
    end else begin
      mulf_complete_o <= 1'b0;
      if (flush_i) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              cnt_q <= 5'd23;
              if (special) begin
                mulf_result_o   <= special_res;
                mulf_complete_o <= 1'b1;
                state_q         <= ST_DONE;
              end else begin
                state_q <= ST_MUL;
              end
            end
          end
          ST_MUL: begin
            if (cnt_q == 5'd0)
              state_q <= ST_NORM;
            else
              cnt_q <= cnt_q - 5'd1;
          end
          ST_NORM: begin
            mulf_result_o   <= norm_round(sign_q, exp_q, prod_q);
            mulf_complete_o <= 1'b1;
            state_q         <= ST_DONE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Datapath: operand capture at accept, product accumulation in MUL
  always_ff @(posedge clk_i) begin
    if (accept) begin
      sign_q  <= res_sign;
      exp_q   <= exp_sum;
      mcand_q <= {1'b1, a_man};
      prod_q  <= {24'd0, 1'b1, b_man};
    end else if (state_q == ST_MUL) begin
      prod_q  <= {mul_sum, prod_q[23:1]};
    end
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_biriscv_mulf.sv
// Bench for biriscv_mulf: directed operand pairs with hand-computed
// results, plus a cycle-level reference model checked every cycle.
module tb_biriscv_mulf;

  logic        clk;
  logic        rst;
  logic        opcode_valid;
  logic        inst_mulf;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        flush;
  logic        busy;
  logic        complete;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  biriscv_mulf dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .opcode_valid_i (opcode_valid),
    .inst_mulf_i    (inst_mulf),
    .operand_ra_i   (ra),
    .operand_rb_i   (rb),
    .flush_i        (flush),
    .busy_o         (busy),
    .mulf_complete_o(complete),
    .mulf_result_o  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference: IEEE rules applied via exact double-precision product,
  // then rounded to single with round-to-nearest-even.
  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                            output int lat);
    logic        s;
    logic        an, bn, ai, bi, az, bz;
    real         pa, pb;
    logic [63:0] db;
    logic [10:0] ea, eb;
    int          e;
    logic [24:0] mant;
    s  = a[31] ^ b[31];
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    lat = 1;
    if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC00000;
    if (ai || bi) return {s, 8'hFF, 23'd0};
    if (az || bz) return {s, 31'd0};
    lat = 26;
    ea = 11'(int'(a[30:23]) + 896);
    eb = 11'(int'(b[30:23]) + 896);
    pa = $bitstoreal({1'b0, ea, a[22:0], 29'd0});
    pb = $bitstoreal({1'b0, eb, b[22:0], 29'd0});
    db = $realtobits(pa * pb);
    e = int'(db[62:52]) - 896;
    mant = {2'b01, db[51:29]};
    if (db[28] && ((|db[27:0]) || mant[0])) mant = mant + 25'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), mant[22:0]};
  endfunction

  // Cycle model: m_remain counts busy cycles still to come.
  int          m_remain = 0;
  logic [31:0] m_pend = 0;
  logic [31:0] m_res = 0;
  logic        m_pulse = 0;

  always @(posedge clk) begin
    int lat;
    m_pulse = 1'b0;
    if (rst) begin
      m_remain = 0;
      m_res = 32'd0;
    end else if (flush) begin
      m_remain = 0;
    end else if (m_remain > 0) begin
      m_remain = m_remain - 1;
      if (m_remain == 1) begin
        m_pulse = 1'b1;
        m_res = m_pend;
      end
    end else if (opcode_valid && inst_mulf) begin
      m_pend = model_mul(ra, rb, lat);
      m_remain = lat;
      if (m_remain == 1) begin
        m_pulse = 1'b1;
        m_res = m_pend;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_cyc", {31'd0, busy}, {31'd0, m_remain != 0});
      check("complete_cyc", {31'd0, complete}, {31'd0, m_pulse});
      check("result_cyc", result, m_res);
    end
  end

  // Called at a negedge: issue now, return once the pulse has been seen.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    ra = a;
    rb = b;
    opcode_valid = 1'b1;
    inst_mulf = 1'b1;
    @(negedge clk);
    opcode_valid = 1'b0;
    inst_mulf = 1'b0;
    check({name, "_busy1"}, {31'd0, busy}, 32'd1);
    lat = 1;
    while (!complete && lat <= 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat > 40) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no pulse after %0d cycles, required %0d", name, lat, exp_lat);
    end else begin
      check({name, "_lat"}, lat, exp_lat);
      check({name, "_res"}, result, exp);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10] = '{
    '{32'h40000000, 32'h40400000, 32'h40C00000, 26},
    '{32'h3F800001, 32'h3F800001, 32'h3F800002, 26},
    '{32'hBFC00000, 32'h40000000, 32'hC0400000, 26},
    '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1},
    '{32'hFF800000, 32'h40000000, 32'hFF800000, 1},
    '{32'h00000001, 32'h3F800000, 32'h00000000, 1},
    '{32'h7F000000, 32'h40000000, 32'h7F800000, 26},
    '{32'h00800000, 32'h00800000, 32'h00000000, 26},
    '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1},
    '{32'h3FC00000, 32'hBFC00000, 32'hC0100000, 26}
  };

  initial begin
    int lat;
    logic [31:0] mres;
    logic [31:0] held;
    rst = 1'b1;
    opcode_valid = 1'b0;
    inst_mulf = 1'b0;
    ra = 32'd0;
    rb = 32'd0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_complete", {31'd0, complete}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Pin the reference model to hand-computed values
    foreach (vecs[i]) begin
      mres = model_mul(vecs[i].a, vecs[i].b, lat);
      check($sformatf("model_%0d", i), mres, vecs[i].exp);
      check($sformatf("model_lat_%0d", i), lat, vecs[i].lat);
    end

    // Directed operations (first one in the cycle right after reset)
    foreach (vecs[i])
      run_op($sformatf("op%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    held = result;

    // Accept at T, ignored request at T+5, flush at T+10
    ra = 32'h40000000;
    rb = 32'h40400000;
    opcode_valid = 1'b1;
    inst_mulf = 1'b1;
    @(negedge clk);
    opcode_valid = 1'b0;
    inst_mulf = 1'b0;
    repeat (4) @(negedge clk);
    ra = 32'h7F800000;
    rb = 32'h00000000;
    opcode_valid = 1'b1;
    inst_mulf = 1'b1;
    @(negedge clk);
    opcode_valid = 1'b0;
    inst_mulf = 1'b0;
    check("busy_ignored_req", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    repeat (30) @(negedge clk);
    check("flush_result_held", result, held);

    // Reset at T+12 of an operation, then accept immediately after
    ra = 32'h40000000;
    rb = 32'h40400000;
    opcode_valid = 1'b1;
    inst_mulf = 1'b1;
    @(negedge clk);
    opcode_valid = 1'b0;
    inst_mulf = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_complete", {31'd0, complete}, 32'd0);
    check("midrst_result", result, 32'd0);
    run_op("after_rst", 32'hBFC00000, 32'h40000000, 32'hC0400000, 26);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/biriscv_mulf.md
BIRISCV_MULF -- requirements
Module: biriscv_mulf

Interface
REQ-001 Parameters: none; all behaviour fixed by this document.
REQ-002 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 opcode_valid_i  input  1  instruction issued this cycle.
REQ-005 inst_mulf_i  input  1  issued instruction is FP single-precision multiply.
REQ-006 operand_ra_i  input  32  binary32 operand A.
REQ-007 operand_rb_i  input  32  binary32 operand B.
REQ-008 flush_i  input  1  pipeline squash, aborts in-flight operation.
REQ-009 busy_o  output  1  high in any state other than IDLE.
REQ-010 mulf_complete_o  output  1  single-cycle pulse, result valid.
REQ-011 mulf_result_o  output  32  binary32 product.

Function
REQ-012 States: IDLE, MUL, NORM, DONE; busy_o = (state != IDLE).
REQ-013 Accept: in IDLE with opcode_valid_i & inst_mulf_i & ~flush_i sampled at edge of cycle T, operands captured, sign = A[31]^B[31].
REQ-014 Requests arriving while busy_o=1 are ignored; no queueing, no state change.
REQ-015 Normal path: MUL for cycles T+1..T+24, NORM in T+25, DONE in T+26; mulf_complete_o=1 only in DONE, then IDLE.
REQ-016 MUL: radix-2 shift-add of 24-bit significands (hidden bit restored), one multiplier bit per cycle, 5-bit down-counter 23..0, 48-bit product.
REQ-017 Exponent: eA+eB-127 computed in 10-bit signed arithmetic at accept.
REQ-018 NORM: if product[47]=1, shift right 1 and exponent+1; round-to-nearest-even on guard bit plus sticky OR of remaining low bits; carry out of rounding renormalises and increments exponent.
REQ-019 Exponent >= 255 after rounding -> signed infinity (exp 0xFF, mantissa 0).
REQ-020 Exponent <= 0 after rounding -> signed zero; no subnormal results.
REQ-021 Subnormal inputs (exp 0, mantissa != 0) treated as signed zero.
REQ-022 Special fast path, DONE in T+1 (complete pulse in T+1), skipping MUL/NORM: any NaN, or inf*zero -> 0x7FC00000; inf*nonzero -> signed infinity; zero*finite -> signed zero.
REQ-023 mulf_result_o registered, updated only on entry to DONE, holds value until next DONE.
REQ-024 flush_i=1 in any state -> IDLE next cycle, no complete pulse, mulf_result_o unchanged; flush wins over simultaneous accept.
REQ-025 flush_i in the DONE cycle does not suppress that cycle's pulse (already presented).
REQ-026 No exception flags produced; NaN output always canonical 0x7FC00000.

Reset
REQ-027 rst_i=1 at an edge -> state IDLE, counter 0, busy_o=0, mulf_complete_o=0, mulf_result_o=0x00000000, regardless of state (including mid-MUL); no pulse follows reset.
REQ-028 Accept is possible in the first cycle after rst_i deasserts.

Verification
REQ-029 0x40000000 * 0x40400000 accepted at T -> mulf_complete_o=1 only at T+26, mulf_result_o=0x40C00000, busy_o high T+1..T+26.
REQ-030 0x3F800001 * 0x3F800001 -> 0x3F800002 (RNE rounding); 0xBFC00000 * 0x40000000 -> 0xC0400000.
REQ-031 0x7F800000 * 0x00000000 -> 0x7FC00000 pulse at T+1; 0xFF800000 * 0x40000000 -> 0xFF800000 at T+1; 0x00000001 * 0x3F800000 -> 0x00000000.
REQ-032 0x7F000000 * 0x40000000 -> 0x7F800000 at T+26; 0x00800000 * 0x00800000 -> 0x00000000.
REQ-033 Accept at T, flush_i at T+10 -> IDLE at T+11, no pulse, result unchanged; second request at T+5 while busy -> ignored.
REQ-034 rst_i at T+12 of an operation -> all outputs reset values next cycle, no pulse; new accept right after reset completes normally at +26.
